// File: rtl/light_pkg.sv
// Shared types for the light mode controller: the mode code driven to the pattern engine,
// the controller state, and the on-mode rotation.
package light_pkg;

   typedef enum logic [2:0] {
      ModeOff   = 3'b000,
      ModeAll   = 3'b100,
      ModeChase = 3'b110,
      ModeAlt   = 3'b111
   } mode_e;

   typedef enum logic [1:0] {
      StOff,
      StAll,
      StChase,
      StAlt
   } ctrl_state_e;

   // ALL -> CHASE -> ALT -> ALL; OFF is never rotated into.
   function automatic ctrl_state_e next_mode(input ctrl_state_e st);
      ctrl_state_e nxt;
      case (st)
         StAll:   nxt = StChase;
         StChase: nxt = StAlt;
         StAlt:   nxt = StAll;
         default: nxt = StOff;
      endcase
      return nxt;
   endfunction

   function automatic mode_e state_to_mode(input ctrl_state_e st);
      mode_e m;
      case (st)
         StAll:   m = ModeAll;
         StChase: m = ModeChase;
         StAlt:   m = ModeAlt;
         default: m = ModeOff;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/button_sync_edge.sv
// Multi-stage synchronizer for one raw asynchronous input, with a one-cycle rising-edge pulse.
module button_sync_edge #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw,
   output logic level,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   level_prev_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q       <= '0;
         level_prev_q <= 1'b0;
      end else begin
         sync_q       <= {sync_q[SYNC_STAGES-2:0], raw};
         level_prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   // A held input yields exactly one pulse.
   assign rise  = level & ~level_prev_q;

endmodule

// File: rtl/light_mode_controller.sv
// Front end for the 4-light pattern engine: turns buttons and the demo switch into a
// registered mode code, a prescaled step strobe and an optional demo auto-cycle.
module light_mode_controller
   import light_pkg::*;
#(
   parameter int unsigned TICK_DIV    = 12_500_000,
   parameter int unsigned DEMO_STEPS  = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       btn_power,
   input  logic       btn_mode,
   input  logic       sw_demo,
   output logic [2:0] mode_code,
   output logic       step,
   output logic       demo_active
);

   localparam int unsigned PreW  = $clog2(TICK_DIV);
   localparam int unsigned DemoW = (DEMO_STEPS > 1) ? $clog2(DEMO_STEPS) : 1;
   localparam logic [PreW-1:0]  PreLast  = PreW'(TICK_DIV - 1);
   localparam logic [DemoW-1:0] DemoLast = DemoW'(DEMO_STEPS - 1);

   ctrl_state_e      state_q, state_d;
   ctrl_state_e      last_on_q, last_on_d;
   mode_e            mode_q;
   logic [PreW-1:0]  pre_q, pre_d;
   logic [DemoW-1:0] demo_cnt_q, demo_cnt_d;

   logic pwr_level, pwr_rise;
   logic mode_level, mode_rise;
   logic demo_level, demo_rise;
   logic is_on, step_raw, btn_evt, demo_adv;
   logic unused_ok;

   button_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_power (
      .clk     (clk),
      .reset_n (reset_n),
      .raw     (btn_power),
      .level   (pwr_level),
      .rise    (pwr_rise)
   );

   button_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mode (
      .clk     (clk),
      .reset_n (reset_n),
      .raw     (btn_mode),
      .level   (mode_level),
      .rise    (mode_rise)
   );

   button_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_demo (
      .clk     (clk),
      .reset_n (reset_n),
      .raw     (sw_demo),
      .level   (demo_level),
      .rise    (demo_rise)
   );

   assign unused_ok = ^{pwr_level, mode_level, demo_rise};

   assign is_on       = (state_q != StOff);
   assign step_raw    = is_on && (pre_q == PreLast);
   assign btn_evt     = pwr_rise | (mode_rise & is_on);
   // A button-driven change suppresses the step; a demo advance keeps it as the last old step.
   assign step        = step_raw & ~btn_evt;
   assign demo_active = demo_level & is_on;
   assign demo_adv    = demo_active & step & (demo_cnt_q == DemoLast);
   assign mode_code   = mode_q;

   always_comb begin
      state_d   = state_q;
      last_on_d = last_on_q;
      if (pwr_rise) begin
         if (state_q == StOff) begin
            state_d = last_on_q;
         end else begin
            state_d   = StOff;
            last_on_d = state_q;
         end
      end else if ((mode_rise && is_on) || demo_adv) begin
         state_d = next_mode(state_q);
      end
   end

   always_comb begin
      pre_d = pre_q;
      if ((state_d != state_q) || !is_on) begin
         pre_d = '0;
      end else if (pre_q == PreLast) begin
         pre_d = '0;
      end else begin
         pre_d = pre_q + 1'b1;
      end
   end

   always_comb begin
      demo_cnt_d = demo_cnt_q;
      if (!demo_active || btn_evt || demo_adv) begin
         demo_cnt_d = '0;
      end else if (step) begin
         demo_cnt_d = demo_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StOff;
         last_on_q  <= StAll;
         mode_q     <= ModeOff;
         pre_q      <= '0;
         demo_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         last_on_q  <= last_on_d;
         mode_q     <= state_to_mode(state_d);
         pre_q      <= pre_d;
         demo_cnt_q <= demo_cnt_d;
      end
   end

endmodule

// File: tb/tb_light_mode_controller.sv
// Bench for light_mode_controller: cycle-by-cycle reference model, a directed vector table,
// hand-written demo/reset sequences and a randomized button/switch run.
module tb_light_mode_controller;

   localparam int TD = 4;
   localparam int DS = 3;
   localparam int SS = 2;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       btn_power;
   logic       btn_mode;
   logic       sw_demo;
   logic [2:0] mode_code;
   logic       step;
   logic       demo_active;

   always #5 clk = ~clk;

   light_mode_controller #(
      .TICK_DIV    (TD),
      .DEMO_STEPS  (DS),
      .SYNC_STAGES (SS)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .btn_power   (btn_power),
      .btn_mode    (btn_mode),
      .sw_demo     (sw_demo),
      .mode_code   (mode_code),
      .step        (step),
      .demo_active (demo_active)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: raw-input history queues stand in for the synchronizers; the mode is an
   // index into a code table (0 = off, 1..3 = ALL/CHASE/ALT).
   bit         hp[$];
   bit         hm[$];
   bit         hd[$];
   int         m_idx;
   int         m_last;
   int         m_pre;
   int         m_dcnt;
   logic [2:0] codes[4] = '{3'b000, 3'b100, 3'b110, 3'b111};

   typedef struct {
      bit         pwr;
      bit         mode;
      bit         demo;
      int         n;
      logic [2:0] code;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit dly(input bit q[$], input int d);
      if (q.size() < d) return 1'b0;
      return q[q.size() - d];
   endfunction

   task automatic model_reset();
      hp.delete();
      hm.delete();
      hd.delete();
      m_idx  = 0;
      m_last = 1;
      m_pre  = 0;
      m_dcnt = 0;
   endtask

   task automatic model_view(output bit pp, output bit pm, output bit on, output bit stp,
                             output bit dem);
      pp  = dly(hp, SS) && !dly(hp, SS + 1);
      pm  = dly(hm, SS) && !dly(hm, SS + 1);
      on  = (m_idx != 0);
      stp = on && (m_pre == TD - 1) && !pp && !pm;
      dem = dly(hd, SS) && on;
   endtask

   task automatic model_update();
      bit pp, pm, on, stp, dem;
      int old;
      model_view(pp, pm, on, stp, dem);
      old = m_idx;
      if (pp) begin
         if (!on) begin
            m_idx = m_last;
         end else begin
            m_last = m_idx;
            m_idx  = 0;
         end
      end else if (pm && on) begin
         m_idx = m_idx % 3 + 1;
      end else if (dem && stp && (m_dcnt + 1 == DS)) begin
         m_idx = m_idx % 3 + 1;
      end
      if (m_idx != old || m_idx == 0) m_pre = 0;
      else m_pre = (m_pre + 1) % TD;
      if (!dem || pp || (pm && on)) m_dcnt = 0;
      else if (stp) m_dcnt = (m_dcnt + 1) % DS;
      hp.push_back(btn_power);
      hm.push_back(btn_mode);
      hd.push_back(sw_demo);
      while (hp.size() > SS + 2) void'(hp.pop_front());
      while (hm.size() > SS + 2) void'(hm.pop_front());
      while (hd.size() > SS + 2) void'(hd.pop_front());
   endtask

   // Compare at the negedge, then advance one clock and land on the next negedge.
   task automatic tick();
      bit pp, pm, on, stp, dem;
      model_view(pp, pm, on, stp, dem);
      chk("mode_code", 32'(mode_code), 32'(codes[m_idx]));
      chk("step", 32'(step), 32'(stp));
      chk("demo_active", 32'(demo_active), 32'(dem));
      @(posedge clk);
      if (reset_n) model_update();
      else model_reset();
      @(negedge clk);
   endtask

   task automatic wait_change(input int max, output int cycles, output logic stp_before);
      logic [2:0] start;
      start      = mode_code;
      cycles     = 0;
      stp_before = 1'b0;
      while (cycles < max && mode_code == start) begin
         stp_before = step;
         tick();
         cycles++;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not reach its end");
      $fatal(1, "timeout");
   end

   initial begin
      int   cyc;
      logic sb;

      vecs.push_back('{pwr: 1, mode: 0, demo: 0, n: 3,  code: 3'b100});
      vecs.push_back('{pwr: 0, mode: 0, demo: 0, n: 3,  code: 3'b100});
      vecs.push_back('{pwr: 0, mode: 1, demo: 0, n: 3,  code: 3'b110});
      vecs.push_back('{pwr: 0, mode: 0, demo: 0, n: 3,  code: 3'b110});
      vecs.push_back('{pwr: 0, mode: 1, demo: 0, n: 3,  code: 3'b111});
      vecs.push_back('{pwr: 0, mode: 0, demo: 0, n: 3,  code: 3'b111});
      vecs.push_back('{pwr: 0, mode: 1, demo: 0, n: 20, code: 3'b100});
      vecs.push_back('{pwr: 0, mode: 0, demo: 0, n: 3,  code: 3'b100});
      vecs.push_back('{pwr: 0, mode: 1, demo: 0, n: 3,  code: 3'b110});
      vecs.push_back('{pwr: 0, mode: 0, demo: 0, n: 3,  code: 3'b110});
      vecs.push_back('{pwr: 0, mode: 1, demo: 0, n: 3,  code: 3'b111});
      vecs.push_back('{pwr: 0, mode: 0, demo: 0, n: 3,  code: 3'b111});
      vecs.push_back('{pwr: 1, mode: 0, demo: 0, n: 3,  code: 3'b000});
      vecs.push_back('{pwr: 0, mode: 0, demo: 0, n: 3,  code: 3'b000});
      vecs.push_back('{pwr: 0, mode: 1, demo: 0, n: 3,  code: 3'b000});
      vecs.push_back('{pwr: 0, mode: 0, demo: 0, n: 3,  code: 3'b000});
      vecs.push_back('{pwr: 1, mode: 0, demo: 0, n: 3,  code: 3'b111});
      vecs.push_back('{pwr: 0, mode: 0, demo: 0, n: 3,  code: 3'b111});
      vecs.push_back('{pwr: 0, mode: 1, demo: 0, n: 3,  code: 3'b100});
      vecs.push_back('{pwr: 0, mode: 0, demo: 0, n: 3,  code: 3'b100});
      vecs.push_back('{pwr: 0, mode: 1, demo: 0, n: 3,  code: 3'b110});
      vecs.push_back('{pwr: 0, mode: 0, demo: 0, n: 3,  code: 3'b110});
      vecs.push_back('{pwr: 1, mode: 1, demo: 0, n: 3,  code: 3'b000});
      vecs.push_back('{pwr: 0, mode: 0, demo: 0, n: 3,  code: 3'b000});
      vecs.push_back('{pwr: 1, mode: 0, demo: 0, n: 3,  code: 3'b110});
      vecs.push_back('{pwr: 0, mode: 0, demo: 0, n: 3,  code: 3'b110});
      vecs.push_back('{pwr: 1, mode: 0, demo: 0, n: 3,  code: 3'b000});
      vecs.push_back('{pwr: 0, mode: 0, demo: 0, n: 3,  code: 3'b000});

      reset_n   = 1'b0;
      btn_power = 1'b0;
      btn_mode  = 1'b0;
      sw_demo   = 1'b0;
      model_reset();
      @(negedge clk);
      repeat (3) tick();
      reset_n = 1'b1;
      repeat (2) tick();

      // Demo auto-cycle: power on with the switch already set.
      btn_power = 1'b1;
      sw_demo   = 1'b1;
      repeat (3) tick();
      chk("demo_power_on_code", 32'(mode_code), 32'h4);
      btn_power = 1'b0;
      wait_change(40, cyc, sb);
      chk("demo_adv1_cycles", 32'(cyc), 32'd12);
      chk("demo_adv1_code", 32'(mode_code), 32'h6);
      chk("demo_adv1_step", 32'(sb), 32'h1);
      wait_change(40, cyc, sb);
      chk("demo_adv2_cycles", 32'(cyc), 32'd12);
      chk("demo_adv2_code", 32'(mode_code), 32'h7);
      // Manual press landing on the second step restarts the demo count.
      repeat (5) tick();
      btn_mode = 1'b1;
      wait_change(10, cyc, sb);
      chk("manual_press_cycles", 32'(cyc), 32'd3);
      chk("manual_press_code", 32'(mode_code), 32'h4);
      btn_mode = 1'b0;
      wait_change(40, cyc, sb);
      chk("demo_after_manual_cycles", 32'(cyc), 32'd12);
      chk("demo_after_manual_code", 32'(mode_code), 32'h6);
      sw_demo = 1'b0;
      wait_change(30, cyc, sb);
      chk("demo_off_no_change", 32'(cyc), 32'd30);
      chk("demo_off_active", 32'(demo_active), 32'h0);
      sw_demo = 1'b1;
      repeat (4) tick();

      // Asynchronous reset in the middle of a clock phase.
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      chk("async_reset_code", 32'(mode_code), 32'h0);
      chk("async_reset_step", 32'(step), 32'h0);
      chk("async_reset_demo", 32'(demo_active), 32'h0);
      btn_power = 1'b0;
      btn_mode  = 1'b0;
      sw_demo   = 1'b0;
      @(negedge clk);
      repeat (2) tick();
      reset_n = 1'b1;
      repeat (2) tick();

      foreach (vecs[i]) begin
         btn_power = vecs[i].pwr;
         btn_mode  = vecs[i].mode;
         sw_demo   = vecs[i].demo;
         repeat (vecs[i].n) tick();
         chk($sformatf("vec%0d_code", i), 32'(mode_code), 32'(vecs[i].code));
      end

      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 24) == 0) btn_power = ~btn_power;
         if ($urandom_range(0, 5) == 0) btn_mode = ~btn_mode;
         if ($urandom_range(0, 79) == 0) sw_demo = ~sw_demo;
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/light_mode_controller.md
Name: light_mode_controller

Overview:
- Front-end controller for the 4-light pattern engine.
- Converts two raw push-buttons and a demo switch into a registered 3-bit mode code (OFF/ALL/CHASE/ALT) plus a one-cycle step strobe from a programmable prescaler.
- Optional auto-cycle demo advances the mode after a fixed number of steps.
- Sits between board I/O and the pattern engine; the engine advances its pattern only on step.

Parameters:
- TICK_DIV, 12_500_000: clk cycles per step strobe (4 Hz at 50 MHz); legal range is 2 or more.
- DEMO_STEPS, 16: steps spent in a mode before demo auto-advance; legal range is 1 or more.
- SYNC_STAGES, 2: flip-flop depth of the input synchronizers; legal range is 2 or more.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- btn_power  in  1  raw asynchronous power button, active high.
- btn_mode  in  1  raw asynchronous mode button, active high.
- sw_demo  in  1  raw asynchronous demo-enable switch, level.
- mode_code  out  3  encoded mode to the pattern engine: OFF=000, ALL=100, CHASE=110, ALT=111.
- step  out  1  one-clk pulse; the pattern engine advances one step.
- demo_active  out  1  high while demo auto-cycle is running.

Behaviour:
- Interface:
  - One clock, clk.
  - Reset is asynchronous and active-low on reset_n.
  - All state is reset asynchronously.
- Reset values:
  - mode_code=000, step=0, demo_active=0.
  - Internal last_on_mode=ALL; prescaler=0; demo step count=0.
  - Synchronizer flip-flops=0.
- Inputs:
  - Each raw input passes through a SYNC_STAGES flip-flop synchronizer.
  - Buttons then go through rising-edge detection, giving one-cycle press pulses.
  - A held button produces exactly one press.
  - sw_demo is used as a synchronized level.
- Latency: with SYNC_STAGES=2, a button high before clk edge 1 updates mode_code on edge 3.
- State machine: states S_OFF, S_ALL, S_CHASE, S_ALT; mode_code is a registered decode of the state.
  - S_OFF + power press -> last_on_mode.
  - S_OFF + mode press -> ignored.
  - Any on-state + power press -> S_OFF, and last_on_mode is saved as the current state.
  - On-state + mode press: S_ALL->S_CHASE->S_ALT->S_ALL.
  - Power press and mode press in the same cycle: power wins and mode is dropped.
- Prescaler:
  - Counts 0..TICK_DIV-1 while in an on-state.
  - step=1 for the single cycle in which the count equals TICK_DIV-1; the count then wraps to 0.
  - In S_OFF, the count is held at 0 and step=0.
  - Any state change (manual or demo) clears the prescaler, so the first step of the new mode comes TICK_DIV cycles after the change.
  - No step is issued in the cycle of a change.
- Demo:
  - demo_active = sync(sw_demo) AND state != S_OFF.
  - While demo_active, the demo count increments on each step.
  - When the count reaches DEMO_STEPS, the mode advances as if mode were pressed, on the same cycle as that step, and the count clears.
  - A manual mode press, a power press, or demo_active falling clears the count.
  - A demo advance coinciding with a button press: the button wins and the count clears.
- Step semantics: the step strobe and the mode_code change are never asserted in the same cycle, except in the demo-advance cycle. There, step is the last step of the old mode.
- Wrap-around: the prescaler and demo count are sized with $clog2 of their parameter and can never exceed their terminal values.
- Reset mid-operation: all outputs return to reset values asynchronously; after release, the first press needs the full synchronizer latency.

Decomposition:
- Package light_pkg holds:
  - mode enum with fixed encodings OFF=3'b000, ALL=3'b100, CHASE=3'b110, ALT=3'b111;
  - controller state typedef;
  - next_mode() function implementing the ALL->CHASE->ALT->ALL rotation.
- Sub-module button_sync_edge (parameter SYNC_STAGES; ports clk, reset_n, raw, level, rise): instantiated for btn_power, btn_mode and sw_demo (rise unused for the switch).
- The prescaler, demo counter and FSM live in the top module.

Test Plan:
- Reset check (TICK_DIV=4, DEMO_STEPS=3): assert reset_n=0 mid-run -> mode_code=000, step=0, demo_active=0 immediately and asynchronously.
- Power-on from reset: power pulse -> mode_code=100 on edge 3; step every 4 clks; second power press -> 000, step stays 0.
- Mode rotation: with power on, press mode 3 times -> 110, 111, 100. Hold mode for 20 clks -> only one advance. Mode press while OFF -> stays 000.
- Resume last mode: in ALT, press power, then press power again -> mode_code=111, not 100.
- Simultaneous presses: power and mode rise in the same cycle while in CHASE -> 000, and last_on_mode=CHASE.
- Demo: sw_demo=1 in ALL -> after 3 steps (12 clks) -> 110 on the 3rd step cycle, then 111 after 3 more. A manual press at step 2 resets the count to 0.
